// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   Multi-cycle radix-2 restoring divider controller for the EX stage.
//   Performs DIV (signed) and DIVU (unsigned), producing one quotient bit
//   per clock. While the EX stage holds a divide and the result is not yet
//   valid, a stall request is raised toward the pipeline stall controller.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   start_i       EX holds a DIV/DIVU (held high while EX is stalled on it)
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start_i in IDLE
//   opdata1_i     dividend, sampled in IDLE
//   opdata2_i     divisor, sampled in IDLE
//   annul_i       pipeline flush; abandons the operation in progress
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   stallreq_o    start_i & ~ready_o (combinational)
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] dvd_reg;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_reg;      // divisor magnitude
  logic [WIDTH-1:0] rem_reg;      // partial remainder
  logic [CW-1:0]    cnt_reg;      // completed steps
  logic             neg_quo_reg;  // operand signs differ
  logic             neg_rem_reg;  // dividend negative

  logic             go;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic             q_bit;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last_step;

  assign go    = start_i & ~annul_i;
  assign neg_a = signed_div_i & opdata1_i[WIDTH-1];
  assign neg_b = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a = neg_a ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs_b = neg_b ? (~opdata2_i + 1'b1) : opdata2_i;

  // The shifted remainder needs WIDTH+1 bits: with a divisor near 2^WIDTH
  // the doubled remainder can exceed WIDTH bits before the subtraction.
  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
  assign q_bit   = (shifted >= {1'b0, dvs_reg});
  // When the trial succeeds the true difference is below the divisor, so
  // the low WIDTH bits of a modular subtraction are exact.
  assign diff     = shifted[WIDTH-1:0] - dvs_reg;
  assign rem_step = q_bit ? diff : shifted[WIDTH-1:0];
  assign quo_step = {dvd_reg[WIDTH-2:0], q_bit};

  // Signed overflow (most negative / -1) wraps naturally through negation.
  assign quo_fix   = neg_quo_reg ? (~quo_step + 1'b1) : quo_step;
  assign rem_fix   = neg_rem_reg ? (~rem_step + 1'b1) : rem_step;
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  assign stallreq_o = start_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (go) begin
            if (opdata2_i == '0) begin
              state_reg <= ST_BYZERO;
            end else begin
              state_reg   <= ST_ON;
              dvd_reg     <= abs_a;
              dvs_reg     <= abs_b;
              neg_quo_reg <= neg_a ^ neg_b;
              neg_rem_reg <= neg_a;
              cnt_reg     <= '0;
              rem_reg     <= '0;
            end
          end
        end

        // Divide by zero yields a zero result, no exception.
        ST_BYZERO: begin
          state_reg <= ST_END;
          result_o  <= '0;
          ready_o   <= 1'b1;
        end

        ST_ON: begin
          if (!go) begin
            state_reg <= ST_IDLE;
            ready_o   <= 1'b0;
            result_o  <= '0;
          end else begin
            rem_reg <= rem_step;
            dvd_reg <= quo_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_step) begin
              result_o  <= {rem_fix, quo_fix};
              ready_o   <= 1'b1;
              state_reg <= ST_END;
            end
          end
        end

        // Hold the result steady while EX remains stalled on this divide.
        ST_END: begin
          if (!go) begin
            state_reg <= ST_IDLE;
            ready_o   <= 1'b0;
            result_o  <= '0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          ready_o   <= 1'b0;
          result_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl
//   Self-checking bench for div_seq_ctrl: directed cases plus randomized
//   divides compared against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic (truncating division, remainder
  // carries the dividend's sign); divide by zero gives zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sg);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Counts rising edges until ready_o, bounded; notes any cycle before
  // ready where the stall request is missing. Scrambles operand buses to
  // show they are ignored once the divide is accepted.
  task automatic wait_ready(input bit scramble, output int n, output bit stall_ok);
    n = 0;
    stall_ok = (stallreq_o === 1'b1);
    while (ready_o !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, output logic [63:0] res);
    logic [63:0] exp;
    int          n, lat;
    bit          stall_ok;
    exp = model(a, b, sg);
    lat = (b == 32'd0) ? 2 : W + 1;
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b0;
    signed_div_i = sg; opdata1_i = a; opdata2_i = b;
    #1;
    wait_ready(1'b1, n, stall_ok);
    res = result_o;
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, result_o, exp);
    chk({tag, " stall"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, " stall_low"}, {63'd0, stallreq_o}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, result_o, exp);
      chk({tag, " hold_rdy"}, {63'd0, ready_o}, 64'd1);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " drop_rdy"}, {63'd0, ready_o}, 64'd0);
    chk({tag, " drop_res"}, result_o, 64'd0);
    $display("div %s a=%h b=%h signed=%0d result=%h edges=%0d", tag, a, b, sg, res, n);
  endtask

  initial begin
    logic [63:0] res;
    logic [31:0] a, b;
    logic        sg;
    int          n;
    bit          stall_ok, seen;

    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_div("u100_7", 32'd100, 32'd7, 1'b0, res);
    chk("u100_7 const", res, {32'd2, 32'd14});
    run_div("s-7_2", 32'hFFFFFFF9, 32'h2, 1'b1, res);
    chk("s-7_2 const", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("s7_-2", 32'h7, 32'hFFFFFFFE, 1'b1, res);
    chk("s7_-2 const", res, {32'h00000001, 32'hFFFFFFFD});
    run_div("s_div0", 32'h12345678, 32'h0, 1'b1, res);
    chk("s_div0 const", res, 64'd0);
    run_div("u_div0", 32'hDEADBEEF, 32'h0, 1'b0, res);
    chk("u_div0 const", res, 64'd0);

    // Annul on step 10
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk);            // start edge
    repeat (9) @(posedge clk); // steps 1..9
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul ready", {63'd0, ready_o}, 64'd0);
    chk("annul result", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) seen = 1'b1;
    end
    chk("annul never_ready", {63'd0, seen}, 64'd0);
    $display("annul at step 10 ready_seen=%0d", seen);
    run_div("u_ffffffff_10", 32'hFFFFFFFF, 32'h10, 1'b0, res);
    chk("u_ffffffff_10 const", res, {32'h0000000F, 32'h0FFFFFFF});

    // Overflow and large divisor
    run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, res);
    chk("s_ovf const", res, {32'h00000000, 32'h80000000});
    run_div("u_big", 32'h80000000, 32'hFFFFFFFF, 1'b0, res);
    chk("u_big const", res, {32'h80000000, 32'h00000000});

    // Reset on step 20, with start held through and after reset
    @(negedge clk);
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_ready(1'b0, n, stall_ok);
    chk("rst_mid restart latency", 64'(n), 64'(W + 1));
    chk("rst_mid restart result", result_o, {32'd2, 32'd14});
    chk("rst_mid restart stall", {63'd0, stall_ok}, 64'd1);
    $display("reset mid-op restart result=%h edges=%0d", result_o, n);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;

    // Randomized divides
    for (int t = 0; t < 24; t++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'h0;
        3:       b = -32'($urandom_range(1, 300));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div($sformatf("rnd%0d", t), a, b, sg, res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
